// File: rtl/lsl8.sv
// 8-bit logical shift left by 0..3 with zero fill; combinational d_out plus registered q_out.
// Latency: d_out is combinational (0 cycles); q_out follows d_out 1 cycle after a clk edge with en=1.
// No backpressure: en gates the q_out load, and q_out holds when en=0.
module lsl8 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] d_in,
  input  logic [1:0] shamt,
  input  logic       en,
  output logic [7:0] d_out,
  output logic [7:0] q_out
);

  logic [7:0] stage0;
  logic [7:0] stage1;

  // Stage 0: each bit picks its own bit or its lower neighbour (shift by 1), zero at bit 0.
  always_comb begin
    stage0 = shamt[0] ? {d_in[6:0], 1'b0} : d_in;
  end

  // Stage 1: each bit picks the stage-0 bit or the one two below (shift by 2), zeros at bits 1:0.
  always_comb begin
    stage1 = shamt[1] ? {stage0[5:0], 2'b00} : stage0;
  end

  assign d_out = stage1;

  // Output register: async clear, load the shifted value when enabled, otherwise hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_out <= 8'h00;
    end else if (en) begin
      q_out <= stage1;
    end
  end

endmodule

// File: tb/tb_lsl8.sv
// Testbench for lsl8: directed test-plan steps followed by exhaustive and randomized sweeps.
// Expected values come from an arithmetic shift model and a tracked register value.
// Inputs change 1 ns after rising edges; outputs are sampled a further 1 ns later.
module tb_lsl8;

  logic       clk;
  logic       reset_n;
  logic [7:0] d_in;
  logic [1:0] shamt;
  logic       en;
  logic [7:0] d_out;
  logic [7:0] q_out;

  int cmp_cnt = 0;
  int err_cnt = 0;
  logic [7:0] q_model;

  lsl8 dut (
    .clk     (clk),
    .reset_n (reset_n),
    .d_in    (d_in),
    .shamt   (shamt),
    .en      (en),
    .d_out   (d_out),
    .q_out   (q_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: multiply by 2**shamt in wide arithmetic, keep the low 8 bits.
  function automatic logic [7:0] ref_shl(input logic [7:0] d, input logic [1:0] s);
    int unsigned wide;
    wide = int'(d) * (1 << s);
    return wide[7:0];
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance through one rising edge, updating the register model, then check q_out.
  task automatic tick(input string tag);
    logic [7:0] nxt;
    nxt = (reset_n && en) ? ref_shl(d_in, shamt) : q_model;
    @(posedge clk);
    #1;
    q_model = nxt;
    check(tag, q_out, q_model);
  endtask

  task automatic apply(input logic [7:0] d, input logic [1:0] s);
    d_in  = d;
    shamt = s;
    #1;
  endtask

  initial begin
    logic [7:0] c5_exp [4];
    logic [7:0] eb_exp [4];
    c5_exp = '{8'hC5, 8'h8A, 8'h14, 8'h28};
    eb_exp = '{8'hEB, 8'hD6, 8'hAC, 8'h58};

    // 1: reset state, q_out stays clear while clocked with en=1
    reset_n = 1'b0;
    en      = 1'b1;
    q_model = 8'h00;
    apply(8'h00, 2'd0);
    check("rst_d_out", d_out, 8'h00);
    check("rst_q_out", q_out, 8'h00);
    tick("rst_q_clk1");
    tick("rst_q_clk2");

    // 2/3: shamt sweeps on two patterns (d_out tracks inputs even in reset)
    for (int s = 0; s < 4; s++) begin
      apply(8'hC5, 2'(s));
      check("sweep_c5", d_out, c5_exp[s]);
      #9;
    end
    for (int s = 0; s < 4; s++) begin
      apply(8'hEB, 2'(s));
      check("sweep_eb", d_out, eb_exp[s]);
      #9;
    end

    // 4: load, then hold with en=0 while d_out moves
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    en      = 1'b1;
    apply(8'hC5, 2'd2);
    tick("load_14");
    check("load_14_abs", q_out, 8'h14);
    en = 1'b0;
    apply(8'hEB, 2'd3);
    check("hold_d_out", d_out, 8'h58);
    tick("hold_q");
    check("hold_q_abs", q_out, 8'h14);

    // 5: load AC, then asynchronous reset between edges
    en = 1'b1;
    apply(8'hEB, 2'd2);
    tick("load_ac");
    check("load_ac_abs", q_out, 8'hAC);
    #3;
    reset_n = 1'b0;
    #1;
    q_model = 8'h00;
    check("async_rst_q", q_out, 8'h00);
    check("async_rst_d", d_out, 8'hAC);
    #1;
    reset_n = 1'b1;
    #1;

    // 6: exhaustive d_in x shamt on d_out and q_out
    en = 1'b1;
    for (int d = 0; d < 256; d++) begin
      for (int s = 0; s < 4; s++) begin
        apply(8'(d), 2'(s));
        check("exh_d_out", d_out, ref_shl(8'(d), 2'(s)));
        tick("exh_q_out");
      end
    end

    // Random traffic with random enable and occasional mid-cycle reset pulses
    for (int i = 0; i < 400; i++) begin
      en = 1'($urandom_range(0, 1));
      apply(8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)));
      check("rnd_d_out", d_out, ref_shl(d_in, shamt));
      if ($urandom_range(0, 19) == 0) begin
        #2;
        reset_n = 1'b0;
        #1;
        q_model = 8'h00;
        check("rnd_rst_q", q_out, 8'h00);
        reset_n = 1'b1;
      end
      tick("rnd_q_out");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
